// File: rtl/mult_pipe_pkg.sv
// mult_pipe_pkg: shared constants for the pipelined multiplier.
//   DEF_WIDTH / DEF_STAGES / DEF_TAG_W : default parameter values for mult_pipe
//   MULT_UNSIGNED / MULT_SIGNED        : encodings of the signed_mode input
package mult_pipe_pkg;

  localparam int DEF_WIDTH  = 64;
  localparam int DEF_STAGES = 8;
  localparam int DEF_TAG_W  = 4;

  localparam logic MULT_UNSIGNED = 1'b0;
  localparam logic MULT_SIGNED   = 1'b1;

endpackage

// File: rtl/mult_pipe_stage.sv
// mult_pipe_stage: one shift-and-add step of the pipelined multiplier.
// Consumes CHUNK multiplier bits per transaction and holds the result with
// its valid bit until the next stage (or the consumer) can take it.
//   clock, reset          : clock, synchronous active-high reset
//   up_valid              : upstream stage holds a transaction
//   up_acc/up_mcand       : upstream partial sum and shifted multiplicand (2*WIDTH)
//   up_mplier             : upstream remaining multiplier bits (WIDTH)
//   up_negate, up_tag     : sign fix-up flag and opaque tag travelling along
//   dn_ready              : downstream can take this stage's contents this cycle
//   valid, acc, mcand_sh,
//   mplier_sh, negate, tag: registered stage contents
module mult_pipe_stage #(
  parameter int WIDTH = 64,
  parameter int CHUNK = 8,
  parameter int TAG_W = 4,
  parameter bit LAST  = 1'b0
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 up_valid,
  input  logic [2*WIDTH-1:0]   up_acc,
  input  logic [2*WIDTH-1:0]   up_mcand,
  input  logic [WIDTH-1:0]     up_mplier,
  input  logic                 up_negate,
  input  logic [TAG_W-1:0]     up_tag,
  input  logic                 dn_ready,
  output logic                 valid,
  output logic [2*WIDTH-1:0]   acc,
  output logic [2*WIDTH-1:0]   mcand_sh,
  output logic [WIDTH-1:0]     mplier_sh,
  output logic                 negate,
  output logic [TAG_W-1:0]     tag
);

  localparam int PW = 2 * WIDTH;

  logic             valid_q, valid_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [PW-1:0]    mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic             negate_q, negate_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             ready;
  logic [PW-1:0]    digit;
  logic [PW-1:0]    sum;

  // Two's complement negate of the full-width sum, modulo 2^PW.
  function automatic logic [PW-1:0] cond_negate(input logic [PW-1:0] x, input logic neg);
    return neg ? -x : x;
  endfunction

  // An empty stage always accepts, so bubbles collapse under backpressure.
  assign ready = !valid_q || dn_ready;

  always_comb begin
    digit    = PW'(up_mplier[CHUNK-1:0]);
    sum      = up_acc + up_mcand * digit;
    valid_d  = valid_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    negate_d = negate_q;
    tag_d    = tag_q;
    if (ready) begin
      valid_d = up_valid;
      if (up_valid) begin
        acc_d    = LAST ? cond_negate(sum, up_negate) : sum;
        // Bits shifted out of the top of mcand would only land above 2^PW.
        mcand_d  = up_mcand << CHUNK;
        mplier_d = up_mplier >> CHUNK;
        negate_d = up_negate;
        tag_d    = up_tag;
      end
    end
  end

  // Only the final stage's acc/tag are visible outputs, so only they get a
  // reset value; earlier data registers are qualified by valid.
  always_ff @(posedge clock) begin
    if (reset) valid_q <= 1'b0;
    else       valid_q <= valid_d;
    mcand_q  <= mcand_d;
    mplier_q <= mplier_d;
    negate_q <= negate_d;
    if (reset && LAST) begin
      acc_q <= '0;
      tag_q <= '0;
    end else begin
      acc_q <= acc_d;
      tag_q <= tag_d;
    end
  end

  assign valid     = valid_q;
  assign acc       = acc_q;
  assign mcand_sh  = mcand_q;
  assign mplier_sh = mplier_q;
  assign negate    = negate_q;
  assign tag       = tag_q;

endmodule

// File: rtl/mult_pipe.sv
// mult_pipe: parametrised pipelined WIDTH x WIDTH -> 2*WIDTH multiplier with
// signed/unsigned mode, a tag carried per operation and valid/ready on both sides.
//   clock, reset          : clock, synchronous active-high reset
//   in_valid, in_ready    : request handshake (in_ready is combinational)
//   mcand, mplier         : operands (WIDTH)
//   signed_mode           : 1 = two's complement operands, 0 = unsigned
//   in_tag                : tag returned with the result
//   out_valid, out_ready  : result handshake
//   product               : full 2*WIDTH product
//   out_tag               : tag of the presented result
module mult_pipe
  import mult_pipe_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STAGES = DEF_STAGES,
  parameter int TAG_W  = DEF_TAG_W
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     mcand,
  input  logic [WIDTH-1:0]     mplier,
  input  logic                 signed_mode,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic [TAG_W-1:0]     out_tag
);

  localparam int CHUNK = WIDTH / STAGES;
  localparam int PW    = 2 * WIDTH;

  if (WIDTH % STAGES != 0) begin : g_width_check
    $error("mult_pipe: WIDTH must be a multiple of STAGES");
  end

  logic [WIDTH-1:0] mcand_mag;
  logic [WIDTH-1:0] mplier_mag;
  logic             negate_in;

  // Signed operands become magnitudes; the product sign is restored at the end.
  // The magnitude of the most negative value still fits unsigned in WIDTH bits.
  always_comb begin
    negate_in  = 1'b0;
    mcand_mag  = mcand;
    mplier_mag = mplier;
    if (signed_mode == MULT_SIGNED) begin
      negate_in = mcand[WIDTH-1] ^ mplier[WIDTH-1];
      if (mcand[WIDTH-1])  mcand_mag  = -mcand;
      if (mplier[WIDTH-1]) mplier_mag = -mplier;
    end
  end

  // Index k is the input of stage k; index STAGES is the pipe output.
  logic [STAGES:0]  vld;
  logic [PW-1:0]    acc_c    [STAGES+1];
  logic [PW-1:0]    mcand_c  [STAGES+1];
  logic [WIDTH-1:0] mplier_c [STAGES+1];
  logic [STAGES:0]  neg_c;
  logic [TAG_W-1:0] tag_c    [STAGES+1];
  logic [STAGES-1:0] dn_ready;
  logic             rdy_chain;

  assign vld[0]      = in_valid;
  assign acc_c[0]    = '0;
  assign mcand_c[0]  = PW'(mcand_mag);
  assign mplier_c[0] = mplier_mag;
  assign neg_c[0]    = negate_in;
  assign tag_c[0]    = in_tag;

  // ready[k] = !valid[k] || ready[k+1], flattened into a look-ahead over the
  // registered valid bits: stage k may advance if the consumer takes the
  // result or any stage below it is empty.
  always_comb begin
    rdy_chain = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      dn_ready[k] = rdy_chain;
      rdy_chain   = rdy_chain || !vld[k+1];
    end
    in_ready = rdy_chain;
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    mult_pipe_stage #(
      .WIDTH (WIDTH),
      .CHUNK (CHUNK),
      .TAG_W (TAG_W),
      .LAST  (k == STAGES - 1)
    ) u_stage (
      .clock     (clock),
      .reset     (reset),
      .up_valid  (vld[k]),
      .up_acc    (acc_c[k]),
      .up_mcand  (mcand_c[k]),
      .up_mplier (mplier_c[k]),
      .up_negate (neg_c[k]),
      .up_tag    (tag_c[k]),
      .dn_ready  (dn_ready[k]),
      .valid     (vld[k+1]),
      .acc       (acc_c[k+1]),
      .mcand_sh  (mcand_c[k+1]),
      .mplier_sh (mplier_c[k+1]),
      .negate    (neg_c[k+1]),
      .tag       (tag_c[k+1])
    );
  end

  assign out_valid = vld[STAGES];
  assign product   = acc_c[STAGES];
  assign out_tag   = tag_c[STAGES];

  // The last stage's shift registers and negate flag have no consumer.
  logic unused_tail;
  assign unused_tail = ^{mcand_c[STAGES], mplier_c[STAGES], neg_c[STAGES]};

endmodule

// File: doc/mult_pipe.md
# mult_pipe

Parametrised pipelined integer multiplier, the successor to the fixed 64-bit, fixed-depth `mult` family. It has configurable operand width and stage count, and produces a full double-width product. Each transaction selects signed or unsigned mode and carries a tag through the pipe. Valid/ready handshakes on both sides allow the pipeline to stall and bubbles to collapse. It sits between issue logic and the writeback/completion path as a multi-cycle functional unit.

## Interface
Parameters:
- `WIDTH`, 64, operand width; must be a multiple of `STAGES`.
- `STAGES`, 8, number of pipeline stages; each stage consumes `WIDTH/STAGES` multiplier bits.
- `TAG_W`, 4, width of the opaque tag carried alongside each operation.

Ports:
- `clock`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  request present.
- `in_ready`  out  1  unit can accept this cycle (combinational).
- `mcand`  in  WIDTH  multiplicand.
- `mplier`  in  WIDTH  multiplier.
- `signed_mode`  in  1  1 = operands are two's complement; 0 = unsigned.
- `in_tag`  in  TAG_W  tag returned with the result.
- `out_valid`  out  1  result present.
- `out_ready`  in  1  consumer accepts result.
- `product`  out  2*WIDTH  full product.
- `out_tag`  out  TAG_W  tag of the presented result.

## Operation
- Input transfer occurs when `in_valid && in_ready`; output transfer occurs when `out_valid && out_ready`.
- Signed mode:
  - Each operand is converted to its magnitude at the input.
  - A negate flag, `mcand[WIDTH-1] ^ mplier[WIDTH-1]`, is carried with the operation.
  - The magnitude of -2^(WIDTH-1) is 2^(WIDTH-1), which fits unsigned in WIDTH bits.
- Stage k (0..STAGES-1) performs:
  - `acc += mcand_sh * mplier_sh[C-1:0]`, where C = WIDTH/STAGES;
  - `mcand_sh <<= C`;
  - `mplier_sh >>= C`.
- `acc` and `mcand_sh` are 2*WIDTH bits wide. The upper bits of `mcand_sh` discarded by the shift never contribute to the product.
- The final stage registers `negate ? -acc : acc`. Result modulo 2^(2*WIDTH):
  - exact for all unsigned inputs;
  - exact for all signed inputs, including (-2^(WIDTH-1))².
- Per-stage valid bit, with `ready[k] = !valid[k] || ready[k+1]`, where `ready[STAGES] = out_ready`.
  - A stage loads from upstream when `ready[k]`; otherwise it holds.
  - `in_ready = ready[0]`.
  - Bubbles collapse: an empty stage accepts even when downstream is stalled.
- Ordering is strictly FIFO; no reordering.
- Reset:
  - all valid bits = 0;
  - `product` = 0, `out_tag` = 0, `out_valid` = 0;
  - `in_ready` = 1 in the first cycle after reset.
- Reset mid-operation discards every in-flight operation; no partial result is ever presented.
- Data registers of invalid stages may hold stale values. `product`/`out_tag` are meaningful only while `out_valid` is high, except for their reset value of 0.

## Timing
- Latency: an operation accepted in cycle t has `out_valid` high in cycle t+STAGES when there are no stalls.
- Throughput: one operation per cycle while `out_ready` is held high.
- Capacity: STAGES in-flight operations. With `out_ready` low, the unit accepts exactly STAGES operations, then `in_ready` drops.
- Output stability: while `out_valid && !out_ready`, `product` and `out_tag` are held stable.
- Simultaneous output pop and input push on a full pipe is allowed: `in_ready = 1` via the ready chain, with no bubble.
- Critical path: one C×2W partial product plus a 2W add per stage; the final stage additionally has a 2W negate.

## Structure
- Package `mult_pipe_pkg`:
  - default `WIDTH`/`STAGES`/`TAG_W` localparams;
  - `localparam MULT_UNSIGNED = 1'b0`, `MULT_SIGNED = 1'b1`.
- Sub-module `mult_pipe_stage`:
  - parametrised by `WIDTH` and `CHUNK`, plus a `LAST` parameter that enables the negate;
  - holds `valid`, `acc`, `mcand_sh`, `mplier_sh`, `negate` and `tag` registers plus the ready logic.
- Top level: input magnitude conversion plus a generate loop chaining the STAGES stage instances.
- Elaboration-time check: `WIDTH % STAGES == 0`.

## Test plan
All cases use WIDTH=64 and STAGES=8 unless stated otherwise.
- Unsigned 3 × 5, tag 4'h3, `out_ready` = 1 → `out_valid` exactly 8 cycles later, product = 128'd15, `out_tag` = 4'h3.
- Signed corner values, each checked independently:
  - -1 × 2 → 128'hFFFF…FFFE;
  - 64'h8000…0 × 64'h8000…0 → 128'h4000_0000_…_0000;
  - unsigned all-ones × all-ones → 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001.
- Back-to-back stream of 100 random mixed-mode operations with `out_ready` = 1 → one result per cycle, all matching the reference model and in tag order.
- Backpressure: `out_ready` = 0 with `in_valid` = 1 for 20 cycles → exactly 8 accepted and `in_ready` = 0 thereafter. Then `out_ready` = 1 → 8 results in order, with `product` held stable throughout the stall.
- Random `in_valid`/`out_ready` (50% each), 1000 operations → no loss, no duplication, FIFO order preserved.
- Assert `reset` for one cycle with 5 operations in flight → next cycle `out_valid` = 0, `product` = 0, `in_ready` = 1, and none of the 5 tags ever emerges. Repeat the whole plan at WIDTH=32, STAGES=4.
